alu_op_sequencer: RTL and testbench

//  Operand-fetch/write-back stage wrapped around the 8-bit ALU: holds a 4x8 register file and C/Z flags.

---
 rtl/alu_seq_pkg.sv | 56 +++++
 rtl/alu_regfile_4x8.sv | 35 +++
 rtl/alu_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, state encoding and select decode for alu_op_sequencer
package alu_seq_pkg;

  // Datapath and register-file geometry
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Instruction opcodes (instr[7:5])
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  // ALU output mux selects (s1:s0)
  localparam logic [1:0] SEL_SUM = 2'b00;
  localparam logic [1:0] SEL_AND = 2'b01;
  localparam logic [1:0] SEL_A   = 2'b10;
  localparam logic [1:0] SEL_B   = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_IMM  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Returns {s4, s3, s2, s1, s0} for an opcode; cin is the carry flag at accept time
  function automatic logic [4:0] op_selects(input logic [2:0] op, input logic cin);
    logic [4:0] sel;
    sel = 5'b00000;
    case (op)
      OP_ADD:  sel = {1'b0, 1'b0, 1'b0, SEL_SUM};
      OP_ADC:  sel = {1'b0, 1'b0, cin,  SEL_SUM};
      OP_SUB:  sel = {1'b0, 1'b1, 1'b1, SEL_SUM};
      OP_SBB:  sel = {1'b0, 1'b1, cin,  SEL_SUM};
      OP_AND:  sel = {1'b0, 1'b0, 1'b0, SEL_AND};
      OP_INC:  sel = {1'b1, 1'b0, 1'b1, SEL_SUM};
      OP_MOV:  sel = {1'b0, 1'b0, 1'b0, SEL_B};
      default: sel = 5'b00000;
    endcase
    return sel;
  endfunction

  // Arithmetic ops whose write-back takes the carry flag from the adder
  function automatic logic op_uses_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
           (op == OP_SBB) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_regfile_4x8.sv
// rtl/alu_regfile_4x8.sv - 4x8 register file: two operand read ports, one debug port, one write port
module alu_regfile_4x8
  import alu_seq_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0]     rdata_a_o,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]     rdata_b_o,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]     dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage: cleared asynchronously, single synchronous write port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - operand-fetch/write-back sequencer around the 8-bit ALU (optional ALU_SEQ_NEG_FLAG_EN adds flag_n)
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [7:0]            instr,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic                  alu_s0,
  output logic                  alu_s1,
  output logic                  alu_s2,
  output logic                  alu_s3,
  output logic                  alu_s4,
  input  logic [DATA_W-1:0]     alu_z,
  input  logic                  alu_carry,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  done,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
`ifdef ALU_SEQ_NEG_FLAG_EN
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  flag_n
`else
  output logic [DATA_W-1:0]     dbg_data
`endif
);

  state_t                state_q;
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     alu_a_q;
  logic [DATA_W-1:0]     alu_b_q;
  logic [DATA_W-1:0]     result_q;
  logic                  carry_q;
  logic [4:0]            sel_q;
  logic                  flag_c_q;
  logic                  flag_z_q;
  logic                  done_q;
  logic                  ready_q;
`ifdef ALU_SEQ_NEG_FLAG_EN
  logic                  flag_n_q;
`endif

  logic                  accept;
  logic                  wb_en;
  logic [DATA_W-1:0]     rd_data;
  logic [DATA_W-1:0]     rs_data;
  logic [4:0]            sel_d;
  logic                  flag_c_d;
  logic                  flag_z_d;

  assign accept = instr_valid && ready_q;
  assign wb_en  = (state_q == ST_WB);

  alu_regfile_4x8 u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (wb_en),
    .waddr_i    (rd_q),
    .wdata_i    (result_q),
    .raddr_a_i  (instr[3:2]),
    .rdata_a_o  (rd_data),
    .raddr_b_i  (instr[1:0]),
    .rdata_b_o  (rs_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Select decode for the incoming opcode; carry-in comes from the flag as it stands now
  always_comb begin
    sel_d = op_selects(instr[7:5], flag_c_q);
  end

  // Flag values committed at write-back; MOV/LDI keep C, AND clears it
  always_comb begin
    flag_c_d = flag_c_q;
    if (op_uses_carry(op_q)) begin
      flag_c_d = carry_q;
    end else if (op_q == OP_AND) begin
      flag_c_d = 1'b0;
    end
    flag_z_d = (result_q == '0);
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      sel_q    <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef ALU_SEQ_NEG_FLAG_EN
      flag_n_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q <= instr[7:5];
            rd_q <= instr[3:2];
            if (instr[7:5] == OP_LDI) begin
              state_q <= ST_IMM;
            end else begin
              alu_a_q <= rd_data;
              alu_b_q <= rs_data;
              sel_q   <= sel_d;
              ready_q <= 1'b0;
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          result_q <= alu_z;
          carry_q  <= alu_carry;
          sel_q    <= '0;
          state_q  <= ST_WB;
        end
        ST_IMM: begin
          if (accept) begin
            result_q <= instr;
            ready_q  <= 1'b0;
            state_q  <= ST_WB;
          end
        end
        ST_WB: begin
          flag_c_q <= flag_c_d;
          flag_z_q <= flag_z_d;
`ifdef ALU_SEQ_NEG_FLAG_EN
          flag_n_q <= result_q[DATA_W-1];
`endif
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          sel_q   <= '0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_s0      = sel_q[0];
  assign alu_s1      = sel_q[1];
  assign alu_s2      = sel_q[2];
  assign alu_s3      = sel_q[3];
  assign alu_s4      = sel_q[4];
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign done        = done_q;
`ifdef ALU_SEQ_NEG_FLAG_EN
  assign flag_n      = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with an 8-bit ALU model
module tb_alu_op_sequencer;

  localparam logic [2:0] T_ADD = 3'd0, T_ADC = 3'd1, T_SUB = 3'd2, T_SBB = 3'd3;
  localparam logic [2:0] T_AND = 3'd4, T_INC = 3'd5, T_MOV = 3'd6, T_LDI = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr = 8'h00;
  logic [7:0] alu_a, alu_b, alu_z;
  logic       alu_s0, alu_s1, alu_s2, alu_s3, alu_s4, alu_carry;
  logic       flag_c, flag_z, done;
  logic [1:0] dbg_addr = 2'd0;
  logic [7:0] dbg_data;
`ifdef ALU_SEQ_NEG_FLAG_EN
  logic       flag_n;
`endif

  int n_chk = 0;
  int n_fail = 0;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s0      (alu_s0),
    .alu_s1      (alu_s1),
    .alu_s2      (alu_s2),
    .alu_s3      (alu_s3),
    .alu_s4      (alu_s4),
    .alu_z       (alu_z),
    .alu_carry   (alu_carry),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .done        (done),
    .dbg_addr    (dbg_addr),
`ifdef ALU_SEQ_NEG_FLAG_EN
    .dbg_data    (dbg_data),
    .flag_n      (flag_n)
`else
    .dbg_data    (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  // 8-bit ALU attached to the sequencer's alu_* ports
  logic [7:0] alu_bm;
  logic [8:0] alu_sum;
  always_comb begin
    alu_bm    = alu_s4 ? 8'h00 : (alu_s3 ? ~alu_b : alu_b);
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_bm} + {8'h00, alu_s2};
    alu_z     = alu_sum[7:0];
    alu_carry = 1'b0;
    case ({alu_s1, alu_s0})
      2'b00: begin alu_z = alu_sum[7:0]; alu_carry = alu_sum[8]; end
      2'b01: alu_z = alu_a & alu_b;
      2'b10: alu_z = alu_a;
      default: alu_z = alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    return {op, 1'b0, rd, rs};
  endfunction

  // Behavioural model: architectural registers/flags plus a countdown to the write-back
  logic [7:0] m_r [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       m_c = 1'b0, m_z = 1'b0, m_n = 1'b0;
  logic       m_ready = 1'b1, m_done = 1'b0, await_imm = 1'b0;
  int         pend_cnt = 0;
  logic [1:0] pend_rd = 2'd0;
  logic [7:0] pend_val = 8'h00;
  logic       pend_c = 1'b0;

  initial begin : model
    int s, borrow;
    logic [7:0] a, b;
    logic [2:0] op;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_c = 0; m_z = 0; m_n = 0; m_ready = 1; m_done = 0;
        await_imm = 0; pend_cnt = 0;
      end else begin
        m_done = 0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            m_r[pend_rd] = pend_val;
            m_c = pend_c;
            m_z = (pend_val == 8'h00);
            m_n = pend_val[7];
            m_done = 1;
            m_ready = 1;
          end
        end else if (m_ready && instr_valid) begin
          if (await_imm) begin
            pend_val = instr; pend_c = m_c; pend_cnt = 1;
            await_imm = 0; m_ready = 0;
          end else begin
            op = instr[7:5];
            pend_rd = instr[3:2];
            a = m_r[instr[3:2]];
            b = m_r[instr[1:0]];
            borrow = m_c ? 0 : 1;
            pend_c = m_c;
            case (op)
              T_ADD: begin s = a + b; pend_val = s[7:0]; pend_c = (s > 255); end
              T_ADC: begin s = a + b + (m_c ? 1 : 0); pend_val = s[7:0]; pend_c = (s > 255); end
              T_SUB: begin s = a - b; pend_val = s[7:0]; pend_c = (a >= b); end
              T_SBB: begin s = a - b - borrow; pend_val = s[7:0]; pend_c = (int'(a) >= int'(b) + borrow); end
              T_AND: begin pend_val = a & b; pend_c = 0; end
              T_INC: begin pend_val = a + 8'd1; pend_c = (a == 8'hFF); end
              T_MOV: pend_val = b;
              default: ;
            endcase
            if (op == T_LDI) await_imm = 1;
            else begin pend_cnt = 2; m_ready = 0; end
          end
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model; rotates the peek address
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("instr_ready", instr_ready, m_ready);
        chk("done", done, m_done);
        chk("flag_c", flag_c, m_c);
        chk("flag_z", flag_z, m_z);
        chk("dbg_data", dbg_data, m_r[dbg_addr]);
`ifdef ALU_SEQ_NEG_FLAG_EN
        chk("flag_n", flag_n, m_n);
`endif
      end
      dbg_addr = dbg_addr + 2'd1;
    end
  end

  // Present a byte from a falling edge and return on the falling edge after it is taken
  task automatic send(input logic [7:0] b, input bit hold = 0);
    int n;
    instr = b;
    instr_valid = 1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 0, 1);
    @(negedge clk);
    if (!hold) instr_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_ready && pend_cnt == 0 && !await_imm) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("idle_timeout", 0, 1);
  endtask

  task automatic ldi(input logic [1:0] rd, input logic [7:0] v);
    send(enc(T_LDI, rd, 2'd0));
    send(v);
    wait_idle();
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    send(enc(op, rd, rs));
    wait_idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int acc;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_done", done, 0);

    // Reset during EXEC aborts the instruction
    ldi(2'd0, 8'h33);
    chk("m_r0_33", m_r[0], 8'h33);
    send(enc(T_ADD, 2'd0, 2'd0));
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    chk("abort_r0", m_r[0], 8'h00);

    // Add with wrap and done latency
    ldi(2'd0, 8'hFF);
    ldi(2'd1, 8'h01);
    send(enc(T_ADD, 2'd0, 2'd1));
    for (int i = 1; i <= 3; i++) begin
      chk("add_done_latency", done, (i == 3) ? 1 : 0);
      if (i < 3) @(negedge clk);
    end
    wait_idle();
    chk("add_r0", m_r[0], 8'h00);
    chk("add_c", flag_c, 1);
    chk("add_z", flag_z, 1);

    // Subtract and subtract-with-borrow
    ldi(2'd2, 8'h05);
    ldi(2'd3, 8'h07);
    alu_op(T_SUB, 2'd2, 2'd3);
    chk("sub_r2", m_r[2], 8'hFE);
    chk("sub_c", flag_c, 0);
    alu_op(T_SBB, 2'd2, 2'd3);
    chk("sbb_r2", m_r[2], 8'hF6);
    chk("sbb_c", flag_c, 1);

    // INC / AND / MOV
    alu_op(T_INC, 2'd1, 2'd0);
    chk("inc_r1", m_r[1], 8'h02);
    chk("inc_c", flag_c, 0);
    chk("inc_z", flag_z, 0);
    alu_op(T_AND, 2'd1, 2'd0);
    chk("and_r1", m_r[1], 8'h00);
    chk("and_c", flag_c, 0);
    chk("and_z", flag_z, 1);
    alu_op(T_MOV, 2'd3, 2'd1);
    chk("mov_r3", m_r[3], 8'h00);
    chk("mov_c", flag_c, 0);
    ldi(2'd0, 8'hFF);
    alu_op(T_INC, 2'd0, 2'd0);
    chk("inc_wrap_c", flag_c, 1);
    ldi(2'd2, 8'h5A);
    alu_op(T_MOV, 2'd3, 2'd2);
    chk("mov_r3_5a", m_r[3], 8'h5A);
    chk("mov_keeps_c", flag_c, 1);
    alu_op(T_ADC, 2'd3, 2'd3);
    chk("adc_rd_eq_rs", m_r[3], 8'hB5);

    // Streaming with valid held high: one accept per three cycles
    instr = enc(T_MOV, 2'd1, 2'd3);
    instr_valid = 1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) acc++;
      @(negedge clk);
    end
    instr_valid = 0;
    chk("stream_accepts", acc, 4);
    wait_idle();

    // Immediate byte delayed while waiting in IMM
    send(enc(T_LDI, 2'd2, 2'd0));
    for (int i = 0; i < 4; i++) begin
      chk("imm_wait_ready", instr_ready, 1);
      @(negedge clk);
    end
    send(8'hA5);
    wait_idle();
    chk("imm_r2", m_r[2], 8'hA5);

`ifdef ALU_SEQ_NEG_FLAG_EN
    ldi(2'd0, 8'h80);
    chk("neg_ldi", flag_n, 1);
    alu_op(T_ADD, 2'd0, 2'd0);
    chk("neg_add_r0", m_r[0], 8'h00);
    chk("neg_add_n", flag_n, 0);
    chk("neg_add_c", flag_c, 1);
    chk("neg_add_z", flag_z, 1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
